scc_wave_core: RTL and testbench

- Wavetable sound generator for the MSX SCC cartridge device: five channels, each with a 32-sample signed 8-bit wave, a 12-bit period, a 4-bit volume and an enable bit.
- Sits directly upstream of the SCC device wrapper. The wrapper decodes CPU cycles in the SCC window (offsets 0x00-0xFF) into this block's register port.
- The wrapper forwards this block's signed 16-bit sound onto its own sound output.
- Channel 4 plays channel 3's wave RAM, as on the original SCC.

---
 rtl/scc_wave_core.sv | 171 +++++++++++++++++
 tb/tb_scc_wave_core.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scc_wave_core.sv
// scc_wave_core -- five-channel SCC wavetable generator.
//
// Each channel has a 32-sample signed 8-bit wave, a 12-bit period, a 4-bit
// volume and an enable bit. Channel 4 has no RAM of its own and plays
// channel 3's wave, as the original SCC does. On every ce tick the per-channel
// counters/pointers step, then a small FSM accumulates the five weighted
// samples one per clk and publishes the mixed, shifted result.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   ce           sound tick, one clk wide, at least 8 clk apart
//   wr, rd       register write / read strobes, one clk wide
//   addr         register offset within the SCC window (0x00-0xFF)
//   din          write data
//   dout         registered read data, valid the clk after rd, held until next rd
//   sound        signed 16-bit mixed sample
//   sample_valid one-clk pulse coinciding with each sound update

module scc_wave_core #(
  parameter int MIX_SHIFT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        wr,
  input  logic        rd,
  input  logic [7:0]  addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic [15:0] sound,
  output logic        sample_valid
);

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, ACC2, ACC3, ACC4, OUT} mix_state_t;

  logic [7:0]  wave_ram [0:127];
  logic [11:0] period   [0:4];
  logic [11:0] counter  [0:4];
  logic [4:0]  ptr      [0:4];
  logic [3:0]  volume   [0:4];
  logic [4:0]  enable;

  logic [4:0]  period_wr;
  logic [11:0] period_new [0:4];

  mix_state_t        state, state_next;
  logic [2:0]        mix_ch;
  logic              mix_active;
  logic [1:0]        ram_ch;
  logic [7:0]        mix_sample;
  logic signed [12:0] sample_ext, volume_ext, mix_prod;
  logic signed [15:0] mix_term;
  logic signed [15:0] acc;

  // Period byte writes: 0x80+2n is the low byte, 0x81+2n the high nibble.
  // The merged value is used both for the period register and the counter
  // reload so a write takes effect immediately.
  always_comb begin
    for (int n = 0; n < 5; n++) begin
      period_wr[n]  = wr && (addr[7:4] == 4'h8) && (addr[3:1] == 3'(n));
      period_new[n] = addr[0] ? {din[3:0], period[n][7:0]} : {period[n][11:8], din};
    end
  end

  // Wave RAM is deliberately not cleared by reset; writes are blocked while
  // reset is high so reset overrides the CPU port.
  always_ff @(posedge clk) begin
    if (!reset && wr && !addr[7])
      wave_ram[addr[6:0]] <= din;
  end

  // Read port: the non-blocking read returns the pre-write byte when a read
  // and write hit the same wave address in one cycle.
  always_ff @(posedge clk) begin
    if (reset)
      dout <= 8'hFF;
    else if (rd)
      dout <= addr[7] ? 8'hFF : wave_ram[addr[6:0]];
  end

  // Channel registers and tone counters. A period write reloads the counter
  // and beats a coincident ce (no decrement, no pointer step). Disabled
  // channels keep stepping so re-enabling them stays in phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 5; n++) begin
        period[n]  <= 12'd0;
        counter[n] <= 12'd0;
        ptr[n]     <= 5'd0;
        volume[n]  <= 4'd0;
      end
      enable <= 5'd0;
    end else begin
      for (int n = 0; n < 5; n++) begin
        if (period_wr[n]) begin
          period[n]  <= period_new[n];
          counter[n] <= period_new[n];
        end else if (ce) begin
          if (counter[n] == 12'd0) begin
            counter[n] <= period[n];
            ptr[n]     <= ptr[n] + 5'd1;
          end else begin
            counter[n] <= counter[n] - 12'd1;
          end
        end
        if (wr && addr == 8'(8'h8A + n))
          volume[n] <= din[3:0];
      end
      if (wr && addr == 8'h8F)
        enable <= din[4:0];
    end
  end

  // Mixer state register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Mixer sequencing: one channel per ACC state. A ce outside IDLE only
  // affects the counters and does not restart the sequence.
  always_comb begin
    state_next = state;
    mix_ch     = 3'd0;
    mix_active = 1'b0;
    case (state)
      IDLE: if (ce) state_next = ACC0;
      ACC0: begin mix_ch = 3'd0; mix_active = 1'b1; state_next = ACC1; end
      ACC1: begin mix_ch = 3'd1; mix_active = 1'b1; state_next = ACC2; end
      ACC2: begin mix_ch = 3'd2; mix_active = 1'b1; state_next = ACC3; end
      ACC3: begin mix_ch = 3'd3; mix_active = 1'b1; state_next = ACC4; end
      ACC4: begin mix_ch = 3'd4; mix_active = 1'b1; state_next = OUT;  end
      OUT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Weighted sample of the channel being accumulated: signed 8-bit wave
  // times unsigned 4-bit volume, both widened to 13 bits so the multiply
  // is fully signed. Channel 4 reads channel 3's RAM.
  always_comb begin
    ram_ch     = (mix_ch == 3'd4) ? 2'd3 : mix_ch[1:0];
    mix_sample = wave_ram[{ram_ch, ptr[mix_ch]}];
    sample_ext = {{5{mix_sample[7]}}, mix_sample};
    volume_ext = {9'd0, volume[mix_ch]};
    mix_prod   = sample_ext * volume_ext;
    mix_term   = enable[mix_ch] ? {{3{mix_prod[12]}}, mix_prod} : 16'sd0;
  end

  // Accumulator and output register. sound and sample_valid are both
  // registered out of OUT so the pulse lines up with the new sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= 16'sd0;
      sound        <= 16'd0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= (state == OUT);
      if (state == IDLE && ce)
        acc <= 16'sd0;
      else if (mix_active)
        acc <= acc + mix_term;
      if (state == OUT)
        sound <= 16'(acc <<< MIX_SHIFT);
    end
  end

endmodule

// File: tb/tb_scc_wave_core.sv
// tb_scc_wave_core -- self-checking bench for scc_wave_core.
// A table of register-port vectors, directed multi-cycle sequences and a
// randomized run, all compared against a behavioural model that derives
// each channel's pointer from the number of ticks since its last period
// write.

module tb_scc_wave_core;

  logic        clk = 1'b0;
  logic        reset, ce, wr, rd;
  logic [7:0]  addr, din;
  logic [7:0]  dout;
  logic [15:0] sound;
  logic        sample_valid;

  int n_checks = 0;
  int n_pass   = 0;

  scc_wave_core #(.MIX_SHIFT(1)) dut (
    .clk(clk), .reset(reset), .ce(ce), .wr(wr), .rd(rd),
    .addr(addr), .din(din), .dout(dout),
    .sound(sound), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [7:0] m_wave [128];
  int m_period [5];
  int m_vol    [5];
  int m_ticks  [5];
  int m_base   [5];
  int m_mask;
  logic [7:0] m_dout;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] exp_dout;
    string      name;
  } vec_t;

  vec_t vecs [12];

  function automatic int m_ptr(input int n);
    return (m_base[n] + m_ticks[n] / (m_period[n] + 1)) % 32;
  endfunction

  function automatic int m_sound();
    int s = 0;
    for (int k = 0; k < 5; k++) begin
      if (m_mask[k]) begin
        int ch = (k == 4) ? 3 : k;
        int w  = int'($signed(m_wave[ch * 32 + m_ptr(k)]));
        s += w * m_vol[k];
      end
    end
    return s * 2;
  endfunction

  task automatic m_reset();
    for (int n = 0; n < 5; n++) begin
      m_period[n] = 0; m_vol[n] = 0; m_ticks[n] = 0; m_base[n] = 0;
    end
    m_mask = 0;
    m_dout = 8'hFF;
  endtask

  task automatic model_cycle(input logic c, input logic w, input logic r,
                             input logic [7:0] a, input logic [7:0] d);
    bit pw [5];
    int ia = int'(a);
    for (int n = 0; n < 5; n++) pw[n] = 0;
    if (r) m_dout = (ia < 128) ? m_wave[ia] : 8'hFF;
    if (w) begin
      if (ia < 128) m_wave[ia] = d;
      else if (ia >= 8'h80 && ia <= 8'h89) begin
        int n = (ia - 8'h80) / 2;
        m_base[n] = m_ptr(n);
        if (ia % 2 == 0) m_period[n] = (m_period[n] & 12'hF00) | int'(d);
        else             m_period[n] = (m_period[n] & 8'hFF) | ((int'(d) & 15) << 8);
        m_ticks[n] = 0;
        pw[n] = 1;
      end else if (ia >= 8'h8A && ia <= 8'h8E) m_vol[ia - 8'h8A] = int'(d) & 15;
      else if (ia == 8'h8F) m_mask = int'(d) & 31;
    end
    if (c) for (int n = 0; n < 5; n++) if (!pw[n]) m_ticks[n]++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic c, input logic w, input logic r,
                               input logic [7:0] a, input logic [7:0] d);
    ce = c; wr = w; rd = r; addr = a; din = d;
    model_cycle(c, w, r, a, d);
    tick();
    ce = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_reset();
  endtask

  // One ce tick, optionally with a coincident write, then wait for the
  // mixed sample and compare it against the model.
  task automatic run_ce(input string name, input logic w, input logic [7:0] a,
                        input logic [7:0] d, input logic chk);
    int exp_s;
    int lat = 1;
    applyStimulus(1'b1, w, 1'b0, a, d);
    exp_s = m_sound();
    if (!chk) begin
      for (int i = 0; i < 7; i++) tick();
    end else begin
      while (!sample_valid && lat < 20) begin
        tick();
        lat++;
      end
      checkOutput({name, "_latency"}, lat, 7);
      checkOutput({name, "_sound"}, int'($signed(sound)), exp_s);
      tick();
      checkOutput({name, "_valid_width"}, int'(sample_valid), 0);
    end
  endtask

  initial begin
    int pulses;
    reset = 1'b0; ce = 1'b0; wr = 1'b0; rd = 1'b0; addr = 8'h00; din = 8'h00;
    for (int i = 0; i < 128; i++) m_wave[i] = 8'h00;
    m_reset();
    tick();
    doReset();
    checkOutput("reset_dout", int'(dout), 8'hFF);
    checkOutput("reset_sound", int'($signed(sound)), 0);
    checkOutput("reset_valid", int'(sample_valid), 0);

    // Put the whole wave RAM in a known state so the model tracks it
    for (int i = 0; i < 128; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(i), 8'($urandom));

    // Register-port vectors: dout expected after each cycle
    vecs[0]  = '{1'b1, 1'b0, 8'h25, 8'hA5, 8'hFF, "wr_hold"};
    vecs[1]  = '{1'b0, 1'b1, 8'h25, 8'h00, 8'hA5, "rd_25"};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, "idle_hold"};
    vecs[3]  = '{1'b0, 1'b1, 8'h8A, 8'h00, 8'hFF, "rd_8A"};
    vecs[4]  = '{1'b1, 1'b0, 8'h80, 8'h12, 8'hFF, "wr_period"};
    vecs[5]  = '{1'b0, 1'b1, 8'h80, 8'h00, 8'hFF, "rd_80"};
    vecs[6]  = '{1'b1, 1'b1, 8'h25, 8'h3C, 8'hA5, "rdwr_same_old"};
    vecs[7]  = '{1'b0, 1'b1, 8'h25, 8'h00, 8'h3C, "rd_25_new"};
    vecs[8]  = '{1'b1, 1'b0, 8'h7F, 8'h81, 8'h3C, "wr_7F"};
    vecs[9]  = '{1'b0, 1'b1, 8'h7F, 8'h00, 8'h81, "rd_7F"};
    vecs[10] = '{1'b0, 1'b1, 8'h90, 8'h00, 8'hFF, "rd_90"};
    vecs[11] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'hFF, "rd_FF"};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].din);
      checkOutput(vecs[i].name, int'(dout), int'(vecs[i].exp_dout));
    end

    // Reset in the middle of a mix
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h40);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h80, 8'd9);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h8A, 8'd15);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h8F, 8'h01);
    run_ce("pre_reset", 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("pre_reset_const", int'($signed(sound)), 1920);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h25, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    doReset();
    checkOutput("midmix_sound", int'($signed(sound)), 0);
    checkOutput("midmix_valid", int'(sample_valid), 0);
    checkOutput("midmix_dout", int'(dout), 8'hFF);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (sample_valid) pulses++;
      tick();
    end
    checkOutput("midmix_no_pulse", pulses, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h8F, 8'h00);
    checkOutput("rd_8F", int'(dout), 8'hFF);
    run_ce("post_reset", 1'b0, 8'h00, 8'h00, 1'b1);

    // Single channel, period 3
    doReset();
    for (int k = 0; k < 32; k++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(k), 8'(k * 4));
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h80, 8'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h81, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h8A, 8'd15);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h8F, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      run_ce("single", 1'b0, 8'h00, 8'h00, 1'b1);
      if (i == 3) checkOutput("single_ce3_const", int'($signed(sound)), 0);
      if (i == 4) checkOutput("single_ce4_const", int'($signed(sound)), 120);
      if (i == 8) checkOutput("single_ce8_const", int'($signed(sound)), 240);
    end

    // Channel 4 plays channel 3's RAM
    doReset();
    for (int k = 8'h60; k < 8'h80; k++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(k), 8'h10);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h8E, 8'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h8F, 8'h10);
    run_ce("alias_pos", 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("alias_pos_const", int'($signed(sound)), 32);
    for (int k = 8'h60; k < 8'h80; k++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(k), 8'hF0);
    run_ce("alias_neg", 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("alias_neg_const", int'($signed(sound)), -32);

    // Full scale both ways, then all channels masked
    doReset();
    for (int k = 0; k < 128; k++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(k), 8'h80);
    for (int k = 8'h8A; k <= 8'h8E; k++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(k), 8'd15);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h8F, 8'h1F);
    run_ce("full_min", 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("full_min_const", int'($signed(sound)), -19200);
    for (int k = 0; k < 128; k++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(k), 8'h7F);
    run_ce("full_max", 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("full_max_const", int'($signed(sound)), 19050);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h8F, 8'h00);
    run_ce("full_mask0", 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("full_mask0_const", int'($signed(sound)), 0);

    // Period rewrite coinciding with ce
    doReset();
    for (int k = 0; k < 32; k++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(32 + k), 8'(k * 3 + 1));
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h82, 8'd100);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h83, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h8B, 8'd15);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h8F, 8'h02);
    for (int i = 0; i < 50; i++) run_ce("silent", 1'b0, 8'h00, 8'h00, 1'b0);
    run_ce("period_wr_ce", 1'b1, 8'h82, 8'h05, 1'b1);
    checkOutput("period_wr_ce_const", int'($signed(sound)), 30);
    for (int i = 1; i <= 6; i++) begin
      run_ce("period_after", 1'b0, 8'h00, 8'h00, 1'b1);
      if (i == 5) checkOutput("period_ce5_const", int'($signed(sound)), 30);
      if (i == 6) checkOutput("period_ce6_const", int'($signed(sound)), 120);
    end

    // Randomized traffic against the model
    doReset();
    for (int it = 0; it < 60; it++) begin
      int nw = $urandom_range(0, 3);
      logic [7:0] a, d;
      for (int j = 0; j < nw; j++) begin
        a = 8'($urandom);
        d = 8'($urandom);
        if (a >= 8'h80 && a <= 8'h89)
          d = a[0] ? (($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00) : 8'($urandom_range(0, 7));
        applyStimulus(1'b0, 1'b1, 1'b0, a, d);
      end
      a = 8'($urandom);
      applyStimulus(1'b0, 1'b0, 1'b1, a, 8'h00);
      checkOutput("rand_rd", int'(dout), int'(m_dout));
      if ($urandom_range(0, 3) == 0) begin
        a = 8'($urandom_range(8'h80, 8'h8F));
        d = 8'($urandom_range(0, 7));
        run_ce("rand_ce_wr", 1'b1, a, d, 1'b1);
      end else begin
        run_ce("rand_ce", 1'b0, 8'h00, 8'h00, 1'b1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
